mac_stream_driver: RTL and testbench

- Traffic generator and checker for a three-operand multiply-accumulate stream engine.
- Sources deterministic operand triples (A, B, C) on three 8-bit Avalon-ST source ports.
- Sinks the 16-bit result stream and compares each result against the expected A*B+C, in order.
- Sits opposite the MAC engine in lab and exam test harnesses; reports pass/fail and an error count on conduit outputs.

---
 rtl/mac_stream_driver.sv | 248 ++++++++++++++++++++++++
 tb/tb_mac_stream_driver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_driver.sv
// Traffic generator and result checker for a three-operand MAC stream engine.
// Issues (A,B,C) triples on three Avalon-ST sources, keeps the expected
// A*B+C values in a small FIFO, and compares returned results in order.
module mac_stream_driver #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned EXP_DEPTH   = 4,
    parameter logic [7:0]  SEED        = 8'h10,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic        start,
    output logic [7:0]  aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic [7:0]  aso_out1_data,
    output logic        aso_out1_valid,
    input  logic        aso_out1_ready,
    output logic [7:0]  aso_out2_data,
    output logic        aso_out2_valid,
    input  logic        aso_out2_ready,
    input  logic [15:0] asi_in0_data,
    input  logic        asi_in0_valid,
    output logic        asi_in0_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  err_count
);

    localparam int unsigned PW = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic [7:0]    idx;
    logic          in_flight;
    logic [2:0]    acc;
    logic [2:0]    valid_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [7:0]    c_q;

    logic [15:0]   mem [EXP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          timeout_q;
    logic [7:0]    err_q;
    logic [15:0]   wd;

    logic [2:0]    ready_vec;
    logic [2:0]    hs;
    logic          vec_done;
    logic          push;
    logic          pop;
    logic [8:0]    idx_after;
    logic [CW-1:0] count_after;
    logic          more;
    logic          launch;
    logic          mismatch;
    logic          start_run;
    logic [16:0]   wd_inc;
    logic          wd_expire;
    logic          busy_nxt;
    logic          to_done;

    // Expected MAC result for a given vector index; A*B+C never exceeds 16 bits.
    function automatic logic [15:0] exp_result(input logic [7:0] i);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        a = i;
        b = i + SEED;
        c = ~i;
        return (16'(a) * 16'(b)) + 16'(c);
    endfunction

    // Handshake, FIFO and watchdog decode shared by the FSM and datapath.
    always_comb begin
        ready_vec   = {aso_out2_ready, aso_out1_ready, aso_out0_ready};
        hs          = valid_q & ready_vec;
        vec_done    = in_flight && (&(acc | hs));
        push        = vec_done;
        pop         = asi_in0_valid && ready_q;
        idx_after   = {1'b0, idx} + 9'(push);
        count_after = count + CW'(push) - CW'(pop);
        more        = idx_after < 9'(NUM_VECTORS);
        launch      = (state == S_SEND) && (!in_flight || vec_done) && more
                      && (count_after != CW'(EXP_DEPTH));
        mismatch    = pop && (asi_in0_data != mem[rd_ptr]);
        start_run   = start && ((state == S_IDLE) || (state == S_DONE));
        wd_inc      = {1'b0, wd} + 17'd1;
        wd_expire   = (state == S_DRAIN) && (count != '0) && !pop
                      && (wd_inc == 17'(TIMEOUT));
    end

    // State register.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and run-phase decode.
    always_comb begin
        state_nxt = state;
        to_done   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (vec_done && !more) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((count == '0) || wd_expire) begin
                    state_nxt = S_DONE;
                    to_done   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt == S_SEND) || (state_nxt == S_DRAIN);
    end

    // Source ports, FIFO pointers, checker status and watchdog.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            idx       <= '0;
            in_flight <= 1'b0;
            acc       <= '0;
            valid_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            wd        <= '0;
        end else if (start_run) begin
            // A new run discards any leftover expectations from an aborted drain.
            idx       <= '0;
            in_flight <= 1'b0;
            acc       <= '0;
            valid_q   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            wd        <= '0;
        end else begin
            if (launch) begin
                in_flight <= 1'b1;
                valid_q   <= 3'b111;
                acc       <= '0;
                a_q       <= idx_after[7:0];
                b_q       <= idx_after[7:0] + SEED;
                c_q       <= ~idx_after[7:0];
            end else if (vec_done) begin
                in_flight <= 1'b0;
                valid_q   <= '0;
                acc       <= '0;
            end else begin
                acc       <= acc | hs;
                valid_q   <= valid_q & ~hs;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                idx    <= idx_after[7:0];
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (mismatch && (err_q != 8'hFF)) begin
                    err_q <= err_q + 8'd1;
                end
            end

            count   <= count_after;
            ready_q <= busy_nxt && (count_after != '0);
            busy_q  <= busy_nxt;

            if ((state == S_DRAIN) && !pop) begin
                wd <= wd_inc[15:0];
            end else begin
                wd <= '0;
            end

            if (to_done) begin
                done_q    <= 1'b1;
                timeout_q <= wd_expire;
                pass_q    <= (err_q == 8'd0) && !wd_expire;
            end
        end
    end

    // Expected-result storage; contents are don't-care until pushed.
    always_ff @(posedge csi_clk) begin
        if (push && !rsi_reset) begin
            mem[wr_ptr] <= exp_result(idx);
        end
    end

    assign aso_out0_data  = a_q;
    assign aso_out1_data  = b_q;
    assign aso_out2_data  = c_q;
    assign aso_out0_valid = valid_q[0];
    assign aso_out1_valid = valid_q[1];
    assign aso_out2_valid = valid_q[2];
    assign asi_in0_ready  = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_mac_stream_driver.sv
// Bench for mac_stream_driver: behavioural MAC peer, operand model and run checks.
module tb_mac_stream_driver;

    localparam int unsigned NV      = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TO      = 10;
    localparam logic [7:0]  SEED_TB = 8'h10;

    logic        clk;
    logic        rsi_reset;
    logic        start;
    logic [7:0]  d0, d1, d2;
    logic        v0, v1, v2;
    logic        r0, r1, r2;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int trip_cnt = 0;
    int acc_cnt = 0;
    int last_pop_edge = 0;

    logic [7:0]  qa [$];
    logic [7:0]  qb [$];
    logic [7:0]  qc [$];
    logic [15:0] rq [$];
    logic [23:0] trip_log [$];

    bit         peer_en = 1'b1;
    int         peer_rate = 100;
    int         peer_limit = 1000;
    logic [7:0] bad_mask = 8'h00;
    logic [2:0] r_force = 3'b111;
    bit         rdy_rand = 1'b0;

    mac_stream_driver #(
        .NUM_VECTORS(NV),
        .EXP_DEPTH  (DEPTH),
        .SEED       (SEED_TB),
        .TIMEOUT    (TO)
    ) dut (
        .csi_clk       (clk),
        .rsi_reset     (rsi_reset),
        .start         (start),
        .aso_out0_data (d0),
        .aso_out0_valid(v0),
        .aso_out0_ready(r0),
        .aso_out1_data (d1),
        .aso_out1_valid(v1),
        .aso_out1_ready(r1),
        .aso_out2_data (d2),
        .aso_out2_valid(v2),
        .aso_out2_ready(r2),
        .asi_in0_data  (res_data),
        .asi_in0_valid (res_valid),
        .asi_in0_ready (res_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time the watchdog.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand triple the driver must emit for vector k.
    function automatic logic [23:0] exp_ops(input int k);
        logic [7:0] i;
        i = 8'(k);
        return {i, i + SEED_TB, ~i};
    endfunction

    // Source ready driver.
    initial begin
        {r2, r1, r0} = 3'b111;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_rand) {r2, r1, r0} = 3'($urandom);
            else          {r2, r1, r0} = r_force;
        end
    end

    // MAC peer: returns results in order, optionally throttled or corrupted.
    initial begin : peer
        int ip;
        ip = 0;
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rsi_reset || start) begin
                res_valid = 1'b0;
                ip = 0;
            end else begin
                if (res_valid && acc_cnt > ip) begin
                    ip++;
                    res_valid = 1'b0;
                end
                if (!res_valid && peer_en && ip < rq.size() && ip < peer_limit
                    && int'($urandom_range(0, 99)) < peer_rate) begin
                    res_data  = rq[ip];
                    res_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: collects handshakes, checks operands and sink readiness.
    initial begin : monitor
        logic [7:0]  a, b, c;
        logic [15:0] r;
        forever begin
            @(negedge clk);
            if (rsi_reset || start) begin
                qa.delete(); qb.delete(); qc.delete();
                rq.delete(); trip_log.delete();
                trip_cnt = 0;
                acc_cnt  = 0;
            end else begin
                if (res_ready) chk("ready_pending", 32'(trip_cnt > acc_cnt), 1);
                if (v0 && r0) qa.push_back(d0);
                if (v1 && r1) qb.push_back(d1);
                if (v2 && r2) qc.push_back(d2);
                if (res_valid && res_ready) begin
                    acc_cnt++;
                    last_pop_edge = cyc + 1;
                end
                while (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    c = qc.pop_front();
                    chk("operands", 32'({a, b, c}), 32'(exp_ops(trip_cnt)));
                    r = (16'(a) * 16'(b)) + 16'(c);
                    if (trip_cnt < 8 && bad_mask[trip_cnt[2:0]]) r = 16'h0000;
                    rq.push_back(r);
                    trip_log.push_back({a, b, c});
                    trip_cnt++;
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic wait_vec(input string tag, input logic [7:0] a);
        int k;
        k = 0;
        @(negedge clk);
        while (!(v0 && d0 == a) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(v0 && d0 == a), 1);
    endtask

    task automatic chk_final(input string tag, input int exp_err, input logic exp_pass,
                             input logic exp_to);
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin : main
        logic [23:0] t1 [4];
        int k;
        int t_edge;
        int exp_e;
        t1 = '{24'h0010FF, 24'h0111FE, 24'h0212FD, 24'h0313FC};
        rsi_reset = 1'b1;
        start     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rsi_reset = 1'b0;
        @(negedge clk);
        chk("rst_status", {16'b0, busy, done, pass, timeout, err_count, v0, v1, v2, res_ready}, 0);

        // Full-rate run with a correct peer.
        do_start();
        wait_done("t1", 500);
        chk_final("t1", 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) chk("t1_ops", 32'(trip_log[i]), 32'(t1[i]));
        chk("t1_results", acc_cnt, NV);
        repeat (5) @(negedge clk);
        chk("t1_done_sticky", 32'(done), 1);

        // Peer corrupts vector 2.
        bad_mask = 8'b0000_0100;
        do_start();
        wait_done("t2", 500);
        chk_final("t2", 1, 1'b0, 1'b0);
        bad_mask = 8'h00;

        // Operand B stalled for five cycles on vector 1.
        do_start();
        wait_vec("t3_v0", 8'h00);
        @(posedge clk); #1 r_force = 3'b101;
        @(negedge clk);
        chk("t3_present", 32'({v2, v1, v0}), 32'(3'b111));
        chk("t3_ops", 32'({d0, d1, d2}), 32'(24'h0111FE));
        repeat (4) begin
            @(negedge clk);
            chk("t3_valid_hold", 32'({v2, v1, v0}), 32'(3'b010));
            chk("t3_b_stable", 32'(d1), 32'h11);
        end
        @(posedge clk); #1 r_force = 3'b111;
        @(negedge clk);
        chk("t3_valid_last", 32'({v2, v1, v0}), 32'(3'b010));
        @(negedge clk);
        chk("t3_next_ops", 32'({v2, v1, v0, d0, d1, d2}), 32'({3'b111, 24'h0212FD}));
        wait_done("t3", 500);
        chk_final("t3", 0, 1'b1, 1'b0);
        chk("t3_pushes", trip_cnt, NV);

        // Silent peer: FIFO fills, sources stall, then release.
        peer_en = 1'b0;
        do_start();
        repeat (40) @(negedge clk);
        chk("t4_issued", trip_cnt, DEPTH);
        chk("t4_stall", 32'({v2, v1, v0}), 0);
        chk("t4_busy", 32'({busy, res_ready}), 32'(2'b11));
        peer_en = 1'b1;
        wait_done("t4", 500);
        chk_final("t4", 0, 1'b1, 1'b0);

        // Peer stops returning: watchdog fires TO cycles after the last result.
        peer_limit = 4;
        do_start();
        k = 0;
        while (trip_cnt < NV && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t5_issued", trip_cnt, NV);
        peer_limit = 5;
        k = 0;
        @(negedge clk);
        while (!timeout && k < 100) begin
            @(negedge clk);
            k++;
        end
        t_edge = cyc;
        chk("t5_timeout_seen", 32'(timeout), 1);
        chk("t5_wd_cycles", t_edge - last_pop_edge, TO);
        chk("t5_accepted", acc_cnt, 5);
        chk_final("t5", 0, 1'b0, 1'b1);
        chk("t5_done", 32'(done), 1);
        peer_limit = 1000;

        // Reset in the middle of SEND, then a clean restart.
        do_start();
        wait_vec("t6_v1", 8'h01);
        @(posedge clk); #1 rsi_reset = 1'b1;
        @(posedge clk); #1 rsi_reset = 1'b0;
        @(negedge clk);
        chk("t6_status", {16'b0, busy, done, pass, timeout, err_count, v0, v1, v2, res_ready}, 0);
        chk("t6_data", 32'({d0, d1, d2}), 0);
        repeat (3) @(negedge clk);
        chk("t6_idle", 32'({busy, v0}), 0);
        do_start();
        wait_vec("t6_restart", 8'h00);
        chk("t6_ops", 32'({d0, d1, d2}), 32'(24'h0010FF));
        wait_done("t6", 500);
        chk_final("t6", 0, 1'b1, 1'b0);

        // Randomized backpressure, peer pacing and corruption.
        for (int r = 0; r < 4; r++) begin
            rdy_rand  = 1'b1;
            peer_rate = int'($urandom_range(70, 100));
            bad_mask  = (r == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
            exp_e     = $countones(bad_mask);
            do_start();
            wait_done("rnd", 3000);
            chk_final("rnd", exp_e, exp_e == 0, 1'b0);
            chk("rnd_results", acc_cnt, NV);
        end
        rdy_rand = 1'b0;
        bad_mask = 8'h00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
